// File: rtl/arb2_mux16_pkg.sv
// arb2_mux16_pkg
// Shared definitions for the two-source round-robin arbiter that sits in
// front of the 16-bit 2:1 mux datapath.
//   slot_state_e : occupancy of the one-entry output slot
//   SRC_A/SRC_B  : source tags carried on out_src and used for sel
//   CNT_W        : width of the burst counter (BURST is at most 15)
//   sat_inc      : saturating increment used by the burst counter
package arb2_mux16_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL_A = 2'd1,
    FULL_B = 2'd2
  } slot_state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int CNT_W = 4;

  // Increment v, but never beyond lim.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] r;
    if (v < lim) begin
      r = v + 4'd1;
    end else begin
      r = lim;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb2_mux16_if.sv
// arb2_mux16_if
// Bundles the two producer channels, the consumer channel and the
// observability outputs of arb2_mux16.
//   a_data/a_valid/a_ready : source A valid/ready channel
//   b_data/b_valid/b_ready : source B valid/ready channel
//   out_data/out_valid/out_ready/out_src : registered downstream channel
//   sel  : current mux select (0 = A, 1 = B)
//   busy : out_valid | a_valid | b_valid
// Modports: slave = arbiter view, master = surrounding producers/consumer.
interface arb2_mux16_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_src;
  logic             sel;
  logic             busy;

  modport slave (
    input  a_data, a_valid, b_data, b_valid, out_ready,
    output a_ready, b_ready, out_data, out_valid, out_src, sel, busy
  );

  modport master (
    output a_data, a_valid, b_data, b_valid, out_ready,
    input  a_ready, b_ready, out_data, out_valid, out_src, sel, busy
  );

endinterface

// File: rtl/arb2_mux16_mux16.sv
// mux16
// Existing 16-bit 2:1 multiplexer used as the shared datapath.
//   a, b : data inputs
//   sel  : 0 passes a, 1 passes b
//   out  : selected word (combinational)
module mux16 (
  output logic [15:0] out,
  input  logic        sel,
  input  logic [15:0] a,
  input  logic [15:0] b
);

  // Plain 2:1 selection.
  always_comb begin
    if (sel) begin
      out = b;
    end else begin
      out = a;
    end
  end

endmodule

// File: rtl/arb2_mux16.sv
// arb2_mux16
// Round-robin arbiter between sources A and B sharing one mux16 datapath.
// The winner's word is captured into a one-entry output register and
// offered downstream with a source tag. A source may hold the grant for at
// most BURST consecutive transfers while the other one is waiting.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : arb2_mux16_if slave modport (A/B inputs, output channel,
//              sel and busy)
module arb2_mux16 #(
  parameter int WIDTH = 16,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  arb2_mux16_if.slave   bus
);

  import arb2_mux16_pkg::*;

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  slot_state_e      state_r;
  slot_state_e      state_nxt_s;
  logic             last_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic             out_src_r;

  logic             winner_s;
  logic             slot_free_s;
  logic             xfer_in_s;
  logic             xfer_out_s;
  logic             sel_s;
  logic             a_ready_s;
  logic             b_ready_s;
  logic [15:0]      mux_out_s;

  mux16 u_mux16 (
    .out (mux_out_s),
    .sel (sel_s),
    .a   (bus.a_data),
    .b   (bus.b_data)
  );

  // Winner selection. cnt_r==0 only right after reset, when no run exists
  // yet; in that case the contested grant goes away from last_r (to A).
  always_comb begin
    winner_s = SRC_A;
    if (bus.a_valid && bus.b_valid) begin
      if ((cnt_r != 4'd0) && (cnt_r < BURST_C)) begin
        winner_s = last_r;
      end else begin
        winner_s = ~last_r;
      end
    end else if (bus.a_valid) begin
      winner_s = SRC_A;
    end else if (bus.b_valid) begin
      winner_s = SRC_B;
    end else begin
      // Idle: point the mux at the source expected to request next.
      winner_s = ~last_r;
    end
  end

  // Slot availability and handshake qualifiers.
  always_comb begin
    slot_free_s = (state_r == EMPTY) | bus.out_ready;
    xfer_out_s  = out_valid_r & bus.out_ready;
    if (winner_s == SRC_B) begin
      xfer_in_s = slot_free_s & bus.b_valid;
    end else begin
      xfer_in_s = slot_free_s & bus.a_valid;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Slot next-state: a load wins over a drain so the slot reloads with no bubble.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY, FULL_A, FULL_B: begin
        if (xfer_in_s) begin
          state_nxt_s = (winner_s == SRC_B) ? FULL_B : FULL_A;
        end else if (xfer_out_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // Mux select and source readies.
  always_comb begin
    sel_s     = winner_s;
    a_ready_s = slot_free_s & (winner_s == SRC_A);
    b_ready_s = slot_free_s & (winner_s == SRC_B);
  end

  // Output word, tag and burst bookkeeping; idle cycles leave last/cnt alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_src_r   <= SRC_A;
      last_r      <= SRC_B;
      cnt_r       <= 4'd0;
    end else begin
      if (xfer_in_s) begin
        out_data_r  <= mux_out_s;
        out_src_r   <= winner_s;
        out_valid_r <= 1'b1;
        last_r      <= winner_s;
        cnt_r       <= (winner_s == last_r) ? sat_inc(cnt_r, BURST_C) : 4'd1;
      end else if (xfer_out_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign bus.a_ready   = a_ready_s;
  assign bus.b_ready   = b_ready_s;
  assign bus.sel       = sel_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_src   = out_src_r;
  assign bus.busy      = out_valid_r | bus.a_valid | bus.b_valid;

endmodule

// File: tb/tb_arb2_mux16.sv
// tb_arb2_mux16
// Directed bench for arb2_mux16: one instance with BURST=4, one with
// BURST=1. Accepted words are queued with their expected tag when the
// stimulus expects a transfer, and checked in order as they leave.
module tb_arb2_mux16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb2_mux16_if #(.WIDTH(16)) if0 ();
  arb2_mux16_if #(.WIDTH(16)) if1 ();

  arb2_mux16 #(.WIDTH(16), .BURST(4)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  arb2_mux16 #(.WIDTH(16), .BURST(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int checks = 0;
  int errors = 0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output-side scoreboard for the BURST=4 instance.
  always @(negedge clk) begin
    if (rst === 1'b0 && if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL out0_extra observed=%h expected=none", {if0.out_src, if0.out_data});
      end else begin
        chk("out0", {15'd0, if0.out_src, if0.out_data}, {15'd0, q0.pop_front()});
      end
    end
  end

  // Output-side scoreboard for the BURST=1 instance.
  always @(negedge clk) begin
    if (rst === 1'b0 && if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL out1_extra observed=%h expected=none", {if1.out_src, if1.out_data});
      end else begin
        chk("out1", {15'd0, if1.out_src, if1.out_data}, {15'd0, q1.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check readies/sel mid-cycle and record an expected accepted word.
  task automatic step(input bit which, input logic ea, input logic eb, input logic es,
                      input bit push, input logic [16:0] ent);
    @(negedge clk);
    #1;
    if (which == 1'b0) begin
      chk("a_ready0", {31'd0, if0.a_ready}, {31'd0, ea});
      chk("b_ready0", {31'd0, if0.b_ready}, {31'd0, eb});
      chk("sel0", {31'd0, if0.sel}, {31'd0, es});
      if (push) q0.push_back(ent);
    end else begin
      chk("a_ready1", {31'd0, if1.a_ready}, {31'd0, ea});
      chk("b_ready1", {31'd0, if1.b_ready}, {31'd0, eb});
      chk("sel1", {31'd0, if1.sel}, {31'd0, es});
      if (push) q1.push_back(ent);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic src;
    rst = 1'b1;
    if0.a_data = 16'h0000; if0.a_valid = 1'b0; if0.b_data = 16'h0000; if0.b_valid = 1'b0;
    if0.out_ready = 1'b0;
    if1.a_data = 16'h0000; if1.a_valid = 1'b0; if1.b_data = 16'h0000; if1.b_valid = 1'b0;
    if1.out_ready = 1'b0;

    // Reset values.
    @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, if0.out_data}, 32'd0);
    chk("rst_out_src", {31'd0, if0.out_src}, 32'd0);
    chk("rst_sel", {31'd0, if0.sel}, 32'd0);
    chk("rst_a_ready", {31'd0, if0.a_ready}, 32'd1);
    chk("rst_b_ready", {31'd0, if0.b_ready}, 32'd0);
    chk("rst_busy", {31'd0, if0.busy}, 32'd0);
    tick();
    rst = 1'b0;

    // Single A word, one-cycle latency.
    if0.a_valid = 1'b1; if0.a_data = 16'h1234; if0.out_ready = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {1'b0, 16'h1234});
    tick();
    if0.a_valid = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 17'd0);
    chk("lat_out_valid", {31'd0, if0.out_valid}, 32'd1);
    chk("lat_out_data", {16'd0, if0.out_data}, 32'h1234);
    chk("lat_out_src", {31'd0, if0.out_src}, 32'd0);
    chk("lat_busy", {31'd0, if0.busy}, 32'd1);
    tick();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 17'd0);
    chk("idle_out_valid", {31'd0, if0.out_valid}, 32'd0);
    chk("idle_busy", {31'd0, if0.busy}, 32'd0);
    tick();

    // Contested stream with BURST=4: A x4, B x4, A.
    do_reset();
    if0.a_valid = 1'b1; if0.a_data = 16'hAAAA;
    if0.b_valid = 1'b1; if0.b_data = 16'hBBBB;
    for (int i = 0; i < 9; i++) begin
      src = (i >= 4 && i < 8) ? 1'b1 : 1'b0;
      step(1'b0, ~src, src, src, 1'b1, {src, (src ? 16'hBBBB : 16'hAAAA)});
      if (i > 0) chk("no_bubble", {31'd0, if0.out_valid}, 32'd1);
      tick();
    end
    if0.a_valid = 1'b0; if0.b_valid = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 17'd0);
    tick();

    // Back-pressure: five stalled cycles, then drain and reload on one edge.
    do_reset();
    if0.a_valid = 1'b1; if0.a_data = 16'h1111;
    if0.b_valid = 1'b1; if0.b_data = 16'h2222;
    if0.out_ready = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {1'b0, 16'h1111});
    tick();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0);
      chk("stall_data", {16'd0, if0.out_data}, 32'h1111);
      chk("stall_valid", {31'd0, if0.out_valid}, 32'd1);
      tick();
    end
    if0.out_ready = 1'b1; if0.a_data = 16'h3333;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {1'b0, 16'h3333});
    tick();
    if0.a_valid = 1'b0; if0.b_valid = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 17'd0);
    chk("reload_data", {16'd0, if0.out_data}, 32'h3333);
    tick();

    // B alone for ten beats saturates its count; A then wins at once.
    if0.b_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if0.b_data = 16'(k);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, {1'b1, 16'(k)});
      tick();
    end
    if0.a_valid = 1'b1; if0.a_data = 16'hAAAA; if0.b_data = 16'h000A;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {1'b0, 16'hAAAA});
    tick();
    if0.a_valid = 1'b0; if0.b_valid = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 17'd0);
    tick();

    // Asynchronous reset while holding a B word.
    if0.b_valid = 1'b1; if0.b_data = 16'h5555; if0.out_ready = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 17'd0);
    tick();
    if0.b_valid = 1'b0;
    #2;
    chk("fullb_valid", {31'd0, if0.out_valid}, 32'd1);
    chk("fullb_src", {31'd0, if0.out_src}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, if0.out_valid}, 32'd0);
    chk("arst_out_data", {16'd0, if0.out_data}, 32'd0);
    chk("arst_out_src", {31'd0, if0.out_src}, 32'd0);
    chk("arst_a_ready", {31'd0, if0.a_ready}, 32'd1);
    chk("arst_b_ready", {31'd0, if0.b_ready}, 32'd0);
    tick();
    rst = 1'b0;
    if0.a_valid = 1'b1; if0.a_data = 16'h6666;
    if0.b_valid = 1'b1; if0.b_data = 16'h7777; if0.out_ready = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {1'b0, 16'h6666});
    tick();
    if0.a_valid = 1'b0; if0.b_valid = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 17'd0);
    tick();

    // BURST=1: strict alternation, sel toggles every cycle.
    if1.a_valid = 1'b1; if1.a_data = 16'hC0C0;
    if1.b_valid = 1'b1; if1.b_data = 16'hD0D0; if1.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      src = (i % 2 == 1) ? 1'b1 : 1'b0;
      step(1'b1, ~src, src, src, 1'b1, {src, (src ? 16'hD0D0 : 16'hC0C0)});
      tick();
    end
    if1.a_valid = 1'b0; if1.b_valid = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 17'd0);
    tick();
    tick();

    chk("sb0_drained", q0.size(), 32'd0);
    chk("sb1_drained", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
